// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and latency constants for the MulDiv arbiter
package muldiv_pkg;

    typedef enum logic [3:0] {
        FN_MUL     = 4'd0,
        FN_MULH    = 4'd1,
        FN_MULHSU  = 4'd2,
        FN_MULHU   = 4'd3,
        FN_DIV     = 4'd4,
        FN_DIVU    = 4'd5,
        FN_REM     = 4'd6,
        FN_REMU    = 4'd7,
        FN_MULW    = 4'd8,
        FN_MULW_R9 = 4'd9,
        FN_MULW_RA = 4'd10,
        FN_MULW_RB = 4'd11,
        FN_DIVW    = 4'd12,
        FN_DIVUW   = 4'd13,
        FN_REMW    = 4'd14,
        FN_REMUW   = 4'd15
    } fn_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int MUL_LAT     = 33;
    localparam int DIV_LAT_MIN = 34;
    localparam int DIV_LAT_MAX = 36;
    localparam int LAT_W       = 6;
    localparam int TAG_W       = 5;
    localparam int FN_W        = 4;

    // No legal operation finishes faster than a multiply.
    function automatic logic lat_out_of_bound(input logic [LAT_W-1:0] lat, input int max_lat);
        return (int'(lat) > max_lat) || (int'(lat) < MUL_LAT);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin priority picker, first valid at or after ptr wins
module rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic [PW-1:0] idx;

    // Walk from the farthest offset back to ptr so the closest valid overwrites.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/muldiv_arbiter.sv
// rtl/muldiv_arbiter.sv - round-robin sharing of one iterative MulDiv unit
module muldiv_arbiter
    import muldiv_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int XLEN    = 32,
    parameter int MAX_LAT = 36
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_fn,
    input  logic [XLEN*NREQ-1:0] req_in1,
    input  logic [XLEN*NREQ-1:0] req_in2,
    input  logic [5*NREQ-1:0]    req_tag,
    input  logic [NREQ-1:0]      req_kill,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [XLEN-1:0]      resp_data,
    output logic [4:0]           resp_tag,
    output logic                 md_req_valid,
    input  logic                 md_req_ready,
    output logic [3:0]           md_req_bits_fn,
    output logic [XLEN-1:0]      md_req_bits_in1,
    output logic [XLEN-1:0]      md_req_bits_in2,
    output logic [4:0]           md_req_bits_tag,
    output logic                 md_kill,
    input  logic                 md_resp_valid,
    output logic                 md_resp_ready,
    input  logic [XLEN-1:0]      md_resp_bits_data,
    input  logic [4:0]           md_resp_bits_tag,
    output logic [5:0]           last_lat,
    output logic                 lat_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e              state, state_nxt;
    logic [PW-1:0]       ptr, owner, next_ptr, win_idx;
    logic [NREQ-1:0]     grant;
    logic [FN_W-1:0]     win_fn;
    logic [XLEN-1:0]     win_in1, win_in2;
    logic [TAG_W-1:0]    win_tag;
    logic [LAT_W-1:0]    lat;
    logic                owner_kill;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        win_idx = '0;
        win_fn  = '0;
        win_in1 = '0;
        win_in2 = '0;
        win_tag = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_idx = PW'(i);
                win_fn  = req_fn[i*4 +: 4];
                win_in1 = req_in1[i*XLEN +: XLEN];
                win_in2 = req_in2[i*XLEN +: XLEN];
                win_tag = req_tag[i*5 +: 5];
            end
        end
    end

    assign owner_kill = req_kill[owner];
    assign next_ptr   = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        resp_valid    = '0;
        md_req_valid  = 1'b0;
        md_resp_ready = 1'b0;
        md_kill       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready = grant;
                    state_nxt = ST_ISSUE;
                end
            end
            // A kill suppresses the issue so the unit never sees a half-cancelled request.
            ST_ISSUE: begin
                if (owner_kill) begin
                    md_kill   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    md_req_valid = 1'b1;
                    if (md_req_ready) state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (owner_kill) begin
                    md_kill   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    md_resp_ready = 1'b1;
                    if (md_resp_valid) state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            ptr             <= '0;
            owner           <= '0;
            md_req_bits_fn  <= '0;
            md_req_bits_in1 <= '0;
            md_req_bits_in2 <= '0;
            md_req_bits_tag <= '0;
            lat             <= '0;
            resp_data       <= '0;
            resp_tag        <= '0;
            last_lat        <= '0;
            lat_err         <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        owner           <= win_idx;
                        md_req_bits_fn  <= win_fn;
                        md_req_bits_in1 <= win_in1;
                        md_req_bits_in2 <= win_in2;
                        md_req_bits_tag <= win_tag;
                    end
                end
                ST_ISSUE: begin
                    if (owner_kill) ptr <= next_ptr;
                    else if (md_req_ready) lat <= 6'd1;
                end
                ST_BUSY: begin
                    if (owner_kill) begin
                        ptr <= next_ptr;
                    end else begin
                        if (lat != 6'd63) lat <= lat + 6'd1;
                        if (md_resp_valid) begin
                            resp_data <= md_resp_bits_data;
                            resp_tag  <= md_resp_bits_tag;
                            last_lat  <= lat;
                            if (lat_out_of_bound(lat, MAX_LAT)) lat_err <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (resp_ready[owner]) ptr <= next_ptr;
                end
                default: ;
            endcase
            // A response with no operation waiting for it means the unit is out of step.
            if (md_resp_valid && state != ST_BUSY) lat_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb/tb_muldiv_arbiter.sv - self-checking bench with a behavioural MulDiv stub
module tb_muldiv_arbiter;
    import muldiv_pkg::*;

    localparam int NREQ = 2;
    localparam int XLEN = 32;
    localparam int MAX_LAT = 36;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid, req_ready, req_kill, resp_valid, resp_ready;
    logic [4*NREQ-1:0]    req_fn;
    logic [XLEN*NREQ-1:0] req_in1, req_in2;
    logic [5*NREQ-1:0]    req_tag;
    logic [XLEN-1:0]      resp_data, md_req_bits_in1, md_req_bits_in2, md_resp_bits_data;
    logic [4:0]           resp_tag, md_req_bits_tag, md_resp_bits_tag;
    logic                 md_req_valid, md_req_ready, md_kill, md_resp_valid, md_resp_ready;
    logic [3:0]           md_req_bits_fn;
    logic [5:0]           last_lat;
    logic                 lat_err;

    int total = 0;
    int bad = 0;
    int force_lat = 0;
    int stub_lat = 0;
    logic [5:0] exp_last_lat;

    always #5 clock = ~clock;

    muldiv_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .MAX_LAT(MAX_LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_fn(req_fn),
        .req_in1(req_in1), .req_in2(req_in2), .req_tag(req_tag), .req_kill(req_kill),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
        .md_req_valid(md_req_valid), .md_req_ready(md_req_ready), .md_req_bits_fn(md_req_bits_fn),
        .md_req_bits_in1(md_req_bits_in1), .md_req_bits_in2(md_req_bits_in2),
        .md_req_bits_tag(md_req_bits_tag), .md_kill(md_kill),
        .md_resp_valid(md_resp_valid), .md_resp_ready(md_resp_ready),
        .md_resp_bits_data(md_resp_bits_data), .md_resp_bits_tag(md_resp_bits_tag),
        .last_lat(last_lat), .lat_err(lat_err)
    );

    // RISC-V M-extension results on 32-bit operands.
    function automatic logic [31:0] ref_result(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (fn[2:0])
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = $unsigned(sa * sb); return p[63:32]; end
            3'd2: begin p = $unsigned(sa * $signed(ub)); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int pick_lat(input logic [3:0] fn);
        if (force_lat != 0) return force_lat;
        if (!fn[2]) return MUL_LAT;
        if (fn[0]) return DIV_LAT_MIN;
        return int'($urandom_range(DIV_LAT_MIN, DIV_LAT_MAX));
    endfunction

    initial begin : stub
        logic hs, killed, rhs, pending;
        logic [3:0] s_fn;
        logic [31:0] s_a, s_b;
        logic [4:0] s_tag;
        int cyc;
        md_req_ready = 1'b1;
        md_resp_valid = 1'b0;
        md_resp_bits_data = '0;
        md_resp_bits_tag = '0;
        pending = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clock);
            hs = md_req_valid && md_req_ready;
            killed = md_kill;
            rhs = md_resp_valid && md_resp_ready;
            s_fn = md_req_bits_fn;
            s_a = md_req_bits_in1;
            s_b = md_req_bits_in2;
            s_tag = md_req_bits_tag;
            @(posedge clock); #1;
            if (reset) begin
                pending = 1'b0;
                md_resp_valid = 1'b0;
            end else begin
                if (killed || rhs) begin
                    pending = 1'b0;
                    md_resp_valid = 1'b0;
                end
                if (hs) begin
                    pending = 1'b1;
                    cyc = 1;
                    stub_lat = pick_lat(s_fn);
                    md_resp_bits_data = ref_result(s_fn, s_a, s_b);
                    md_resp_bits_tag = s_tag;
                end else if (pending) begin
                    cyc++;
                end
                if (pending && cyc == stub_lat) md_resp_valid = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        req_valid = '0;
        req_kill = '0;
        resp_ready = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic drive_req(input int r, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] tag);
        req_valid[r] = 1'b1;
        req_fn[r*4 +: 4] = fn;
        req_in1[r*32 +: 32] = a;
        req_in2[r*32 +: 32] = b;
        req_tag[r*5 +: 5] = tag;
    endtask

    task automatic run_op(input int r, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic ok, output logic [31:0] d, output logic [4:0] t);
        int n;
        ok = 1'b0;
        d = '0;
        t = '0;
        @(posedge clock); #1;
        drive_req(r, fn, a, b, tag);
        n = 0;
        @(negedge clock);
        while (!req_ready[r] && n < 200) begin @(negedge clock); n++; end
        @(posedge clock); #1;
        req_valid[r] = 1'b0;
        if (n >= 200) return;
        n = 0;
        @(negedge clock);
        while (!resp_valid[r] && n < 200) begin @(negedge clock); n++; end
        if (n >= 200) return;
        d = resp_data;
        t = resp_tag;
        resp_ready[r] = 1'b1;
        @(posedge clock); #1;
        resp_ready[r] = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        logic ok;
        logic [31:0] d;
        logic [4:0] t;
        do_reset();
        run_op(1, FN_MULHU, 32'h12345678, 32'h9ABCDEF0, 5'h11, ok, d, t);
        @(posedge clock); #1;
        drive_req(0, FN_DIV, 32'd100, 32'd7, 5'h01);
        repeat (6) @(posedge clock);
        #1 req_valid = '0;
        reset = 1'b1;
        @(negedge clock);
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        total++; if (resp_valid !== '0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        total++; if ({md_req_valid, md_resp_ready, md_kill} !== 3'b000) begin
            bad++; $display("FAIL reset_md_ctrl: got %b want 000", {md_req_valid, md_resp_ready, md_kill});
        end
        total++; if (resp_data !== '0 || resp_tag !== '0) begin
            bad++; $display("FAIL reset_resp_bus: got %h/%h want 0/0", resp_data, resp_tag);
        end
        total++; if (last_lat !== '0 || lat_err !== 1'b0) begin
            bad++; $display("FAIL reset_lat: got %0d/%b want 0/0", last_lat, lat_err);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_basic();
        logic ok;
        logic [31:0] d;
        logic [4:0] t;
        run_op(0, FN_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h0A, ok, d, t);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got 0 want 1"); end
        total++; if (d !== 32'h00000001 || t !== 5'h0A) begin
            bad++; $display("FAIL basic_data: got %h/%h want 00000001/0a", d, t);
        end
        total++; if (last_lat !== 6'd33 || lat_err !== 1'b0) begin
            bad++; $display("FAIL basic_lat: got %0d/%b want 33/0", last_lat, lat_err);
        end
        exp_last_lat = 6'd33;
    endtask

    task automatic test_rotation();
        logic [NREQ-1:0] pend, acc, exp_oh, exp_rv;
        logic [31:0] ed [NREQ];
        logic [4:0] et [NREQ];
        logic [3:0] f;
        logic [31:0] a, b;
        logic [4:0] tg;
        int exp_ptr, cur, guard, served, w;
        do_reset();
        exp_ptr = 0;
        cur = 0;
        for (int rnd = 0; rnd < 2; rnd++) begin
            @(posedge clock); #1;
            for (int r = 0; r < NREQ; r++) begin
                f = 4'($urandom_range(0, 15));
                a = $urandom;
                b = $urandom;
                tg = 5'($urandom);
                drive_req(r, f, a, b, tg);
                ed[r] = ref_result(f, a, b);
                et[r] = tg;
            end
            pend = '1;
            served = 0;
            guard = 0;
            while (served < NREQ && guard < 1000) begin
                @(negedge clock);
                guard++;
                if (req_ready != '0) begin
                    w = -1;
                    for (int k = 0; k < NREQ; k++)
                        if (w < 0 && pend[(exp_ptr + k) % NREQ]) w = (exp_ptr + k) % NREQ;
                    exp_oh = '0;
                    exp_oh[w] = 1'b1;
                    total++; if (req_ready !== exp_oh) begin
                        bad++; $display("FAIL rotation_grant: got %b want %b", req_ready, exp_oh);
                    end
                    acc = req_ready;
                    for (int k = 0; k < NREQ; k++) if (acc[k]) cur = k;
                    @(posedge clock); #1;
                    req_valid = req_valid & ~acc;
                    pend = pend & ~acc;
                end else if (resp_valid != '0) begin
                    exp_rv = '0;
                    exp_rv[cur] = 1'b1;
                    total++; if (resp_valid !== exp_rv || resp_data !== ed[cur] || resp_tag !== et[cur]) begin
                        bad++; $display("FAIL rotation_resp: got %b %h %h want %b %h %h",
                                        resp_valid, resp_data, resp_tag, exp_rv, ed[cur], et[cur]);
                    end
                    resp_ready = resp_valid;
                    @(posedge clock); #1;
                    resp_ready = '0;
                    exp_ptr = (cur + 1) % NREQ;
                    served++;
                end
            end
            total++; if (served != NREQ) begin bad++; $display("FAIL rotation_timeout: got %0d want %0d", served, NREQ); end
        end
        exp_last_lat = 6'(stub_lat);
    endtask

    task automatic test_div();
        logic ok;
        logic [31:0] d;
        logic [4:0] t;
        run_op(1, FN_DIV, 32'd0, 32'd0, 5'h1F, ok, d, t);
        total++; if (!ok || d !== 32'hFFFFFFFF || t !== 5'h1F) begin
            bad++; $display("FAIL div_zero: got ok=%b %h/%h want 1 ffffffff/1f", ok, d, t);
        end
        total++; if (int'(last_lat) < DIV_LAT_MIN || int'(last_lat) > DIV_LAT_MAX || last_lat !== 6'(stub_lat)) begin
            bad++; $display("FAIL div_lat: got %0d want %0d in 34..36", last_lat, stub_lat);
        end
        total++; if (lat_err !== 1'b0) begin bad++; $display("FAIL div_err: got %b want 0", lat_err); end
        exp_last_lat = 6'(stub_lat);
    endtask

    task automatic test_kill();
        int n;
        logic seen;
        @(posedge clock); #1;
        drive_req(0, FN_DIVU, 32'd1000, 32'd3, 5'h05);
        n = 0;
        @(negedge clock);
        while (!req_ready[0] && n < 200) begin @(negedge clock); n++; end
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        n = 0;
        @(negedge clock);
        while (!md_resp_ready && n < 200) begin @(negedge clock); n++; end
        total++; if (n >= 200) begin bad++; $display("FAIL kill_busy_timeout: got %0d want <200", n); end
        repeat (4) @(negedge clock);
        @(posedge clock); #1;
        req_kill[1] = 1'b1;
        @(negedge clock);
        total++; if (md_kill !== 1'b0 || md_resp_ready !== 1'b1) begin
            bad++; $display("FAIL kill_nonowner: got kill=%b busy=%b want 0/1", md_kill, md_resp_ready);
        end
        @(posedge clock); #1;
        req_kill[1] = 1'b0;
        repeat (3) @(posedge clock);
        #1 req_kill[0] = 1'b1;
        @(negedge clock);
        total++; if (md_kill !== 1'b1 || resp_valid !== '0) begin
            bad++; $display("FAIL kill_pulse: got kill=%b rv=%b want 1/00", md_kill, resp_valid);
        end
        @(posedge clock); #1;
        req_kill[0] = 1'b0;
        @(negedge clock);
        total++; if ({md_kill, md_resp_ready, md_req_valid} !== 3'b000) begin
            bad++; $display("FAIL kill_idle: got %b want 000", {md_kill, md_resp_ready, md_req_valid});
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (resp_valid != '0 || md_kill) seen = 1'b1;
        end
        total++; if (seen !== 1'b0 || last_lat !== exp_last_lat) begin
            bad++; $display("FAIL kill_no_resp: got seen=%b lat=%0d want 0/%0d", seen, last_lat, exp_last_lat);
        end
        @(posedge clock); #1;
        drive_req(0, FN_MUL, 32'd2, 32'd3, 5'h02);
        drive_req(1, FN_MUL, 32'd4, 32'd5, 5'h03);
        @(negedge clock);
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL kill_ptr_advance: got %b want 10", req_ready); end
        do_reset();
    endtask

    task automatic test_stall();
        logic [31:0] a, b, d0;
        logic [4:0] t0;
        logic stable;
        int n;
        a = $urandom;
        b = $urandom;
        @(posedge clock); #1;
        drive_req(1, FN_MULH, a, b, 5'h16);
        n = 0;
        @(negedge clock);
        while (!req_ready[1] && n < 200) begin @(negedge clock); n++; end
        @(posedge clock); #1;
        req_valid[1] = 1'b0;
        n = 0;
        @(negedge clock);
        while (!resp_valid[1] && n < 200) begin @(negedge clock); n++; end
        d0 = resp_data;
        t0 = resp_tag;
        total++; if (d0 !== ref_result(FN_MULH, a, b) || t0 !== 5'h16) begin
            bad++; $display("FAIL stall_data: got %h/%h want %h/16", d0, t0, ref_result(FN_MULH, a, b));
        end
        @(posedge clock); #1;
        drive_req(0, FN_REMU, 32'd17, 32'd5, 5'h04);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (resp_valid !== 2'b10 || resp_data !== d0 || resp_tag !== t0 || req_ready !== '0) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL stall_hold: got %b want 1", stable); end
        resp_ready[1] = 1'b1;
        @(posedge clock); #1;
        resp_ready[1] = 1'b0;
        @(negedge clock);
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL stall_next_grant: got %b want 01", req_ready); end
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        n = 0;
        @(negedge clock);
        while (!resp_valid[0] && n < 200) begin @(negedge clock); n++; end
        total++; if (resp_data !== 32'd2 || last_lat !== 6'd34) begin
            bad++; $display("FAIL stall_second: got %h/%0d want 00000002/34", resp_data, last_lat);
        end
        resp_ready[0] = 1'b1;
        @(posedge clock); #1;
        resp_ready[0] = 1'b0;
    endtask

    task automatic test_random();
        logic ok;
        logic [31:0] d, a, b;
        logic [4:0] t, tg;
        logic [3:0] f;
        int r, lo, hi;
        for (int it = 0; it < 24; it++) begin
            r = int'($urandom_range(0, NREQ - 1));
            f = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            b = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFFFFFF) : $urandom;
            tg = 5'($urandom);
            run_op(r, f, a, b, tg, ok, d, t);
            if (f inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11}) begin lo = 33; hi = 33; end
            else if (f inside {4'd5, 4'd7, 4'd13, 4'd15}) begin lo = 34; hi = 34; end
            else begin lo = 34; hi = 36; end
            total++; if (!ok || d !== ref_result(f, a, b) || t !== tg) begin
                bad++; $display("FAIL random_op fn=%0d a=%h b=%h: got ok=%b %h/%h want %h/%h",
                                f, a, b, ok, d, t, ref_result(f, a, b), tg);
            end
            total++; if (int'(last_lat) < lo || int'(last_lat) > hi || last_lat !== 6'(stub_lat) || lat_err !== 1'b0) begin
                bad++; $display("FAIL random_lat fn=%0d: got %0d err=%b want %0d in %0d..%0d err=0",
                                f, last_lat, lat_err, stub_lat, lo, hi);
            end
        end
    endtask

    task automatic test_lat_err();
        logic ok;
        logic [31:0] d;
        logic [4:0] t;
        int lats [4] = '{32, 33, 36, 37};
        logic errs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        force_lat = 40;
        run_op(0, FN_MUL, 32'd6, 32'd7, 5'h07, ok, d, t);
        total++; if (!ok || last_lat !== 6'd40 || lat_err !== 1'b1) begin
            bad++; $display("FAIL laterr_set: got ok=%b %0d/%b want 1 40/1", ok, last_lat, lat_err);
        end
        force_lat = 0;
        run_op(1, FN_MUL, 32'd6, 32'd7, 5'h08, ok, d, t);
        total++; if (!ok || d !== 32'd42 || last_lat !== 6'd33 || lat_err !== 1'b1) begin
            bad++; $display("FAIL laterr_sticky: got ok=%b %h %0d/%b want 1 2a 33/1", ok, d, last_lat, lat_err);
        end
        do_reset();
        total++; if (lat_err !== 1'b0) begin bad++; $display("FAIL laterr_clear: got %b want 0", lat_err); end
        for (int k = 0; k < 4; k++) begin
            force_lat = lats[k];
            run_op(k % NREQ, FN_DIVU, 32'd9, 32'd2, 5'(k), ok, d, t);
            total++; if (!ok || int'(last_lat) != lats[k] || lat_err !== errs[k]) begin
                bad++; $display("FAIL laterr_bound lat=%0d: got ok=%b %0d/%b want 1 %0d/%b",
                                lats[k], ok, last_lat, lat_err, lats[k], errs[k]);
            end
            do_reset();
        end
        force_lat = 0;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_kill = '0;
        resp_ready = '0;
        req_fn = '0;
        req_in1 = '0;
        req_in2 = '0;
        req_tag = '0;
        exp_last_lat = '0;
        test_reset();
        test_basic();
        test_rotation();
        test_div();
        test_kill();
        test_stall();
        test_random();
        test_lat_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_arbiter.md
# muldiv_arbiter

Shares one iterative MulDiv unit between NREQ requesters (integer pipe, FPU-to-int path, debug/formal harness). Round-robin grant, exactly one operation in flight, owner-tagged response routing, per-requester kill forwarding and a latency monitor that flags any operation exceeding the unit's documented bound. Sits between the requesters and the MulDiv instance; MulDiv ports are passed through unmodified apart from valid/ready/kill gating.

## Interface
- NREQ, 2: requester count (2..4)
- XLEN, 32: operand/result width
- MAX_LAT, 36: highest legal issue-to-response latency in cycles
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; all state cleared
- req_valid / req_ready  in / out  NREQ  per-requester request handshake
- req_fn  in  4*NREQ  MulDiv function code, slice i for requester i
- req_in1, req_in2  in  XLEN*NREQ  operands
- req_tag  in  5*NREQ  requester tag, returned with result
- req_kill  in  NREQ  requester i kills its in-flight operation
- resp_valid / resp_ready  out / in  NREQ  per-requester response handshake
- resp_data  out  XLEN  result (shared bus, valid only with resp_valid[i])
- resp_tag  out  5  tag of returned result
- md_req_valid/ready, md_req_bits_fn/in1/in2/tag, md_kill  out/in/out/out  1,1,4,XLEN,XLEN,5,1  to MulDiv
- md_resp_valid/ready, md_resp_bits_data/tag  in/out/in/in  1,1,XLEN,5
- last_lat  out  6  latency of most recent completed operation
- lat_err  out  1  sticky: a response arrived with latency > MAX_LAT or < 33

## Operation
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE: if any req_valid, pick winner by round-robin starting at ptr; latch owner, fn, in1, in2, tag; go ISSUE. req_ready[winner]=1 this cycle only (request accepted in IDLE).
- ISSUE: md_req_valid=1 with latched fields; on md_req_ready go BUSY, lat counter:=1.
- BUSY: lat increments each cycle, saturating at 63. md_resp_ready=1. On md_resp_valid: capture data/tag, last_lat:=lat, check bound, go RESP.
- RESP: resp_valid[owner]=1, resp_data/resp_tag from capture; on resp_ready[owner] go IDLE, ptr:=owner+1 mod NREQ.
- Kill: req_kill[owner] in ISSUE or BUSY -> md_kill=1 that cycle, no response delivered, go IDLE, ptr advances, latency not recorded. req_kill from non-owners ignored. Kill in RESP ignored (result already delivered to buffer; requester must drain it).
- md_resp_valid outside BUSY: ignored, lat_err set.
- Bound check: lat_err:=1 when captured lat>MAX_LAT or <33; cleared only by reset.

## Timing
- Reset values: all ready/valid outputs 0, md_kill 0, resp_data 0, resp_tag 0, last_lat 0, lat_err 0, ptr 0, state IDLE.
- Latency convention: lat=1 in first BUSY cycle; MUL-class fn (0-3, 8-11) must report 33; DIV/REM signed (4,6,12,14) 34-36; unsigned (5,7,13,15) 34.
- Arbiter overhead: request accept (IDLE) -> md issue (ISSUE) 1 cycle; md response -> resp_valid 1 cycle.
- No bypass: a new grant occurs the cycle after RESP handshake, never the same cycle.
- Reset mid-operation: immediately IDLE; MulDiv is reset by the same signal.

## Structure
- Package muldiv_pkg: fn code enum (MUL..REMUW), state enum, MUL_LAT=33, DIV_LAT_MIN=34, DIV_LAT_MAX=36.
- Sub-module rr_pick: NREQ-wide round-robin priority picker (valid vector, ptr -> one-hot grant).

## Test plan
- Reset, requester0 fn=0 in1=0xFFFFFFFF in2=0xFFFFFFFF -> resp_valid[0], resp_data=0x00000001, last_lat=33, lat_err=0.
- Both valid in IDLE after reset -> req0 granted first, then req1; third concurrent pair grants req0 again (rotation).
- Requester1 fn=4 in1=0 in2=0 -> resp_data=0xFFFFFFFF, 34<=last_lat<=36, lat_err=0.
- Owner asserts req_kill 10 cycles into BUSY -> md_kill pulse one cycle, no resp_valid, IDLE next cycle; non-owner kill has no effect.
- resp_ready held low 5 cycles in RESP -> resp_valid/data/tag stable, no new grant until handshake.
- Stub MulDiv responding at lat=40 -> lat_err=1 and stays 1 until reset.
